// File: rtl/onehot_index_encoder.sv
// Captures a WIDTH-bit mask and serialises each set bit as a binary index plus
// one-hot code, one per transfer, lowest-first or highest-first.
module onehot_index_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_last,
    output logic             zero_mask
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   pend, pend_next;
    logic               zero_next;
    logic [IDX_W-1:0]   sel_idx;
    logic [WIDTH-1:0]   sel_onehot;
    logic               sel_last;

    // Scan so that the winning bit is visited last: it overwrites any earlier hit.
    always_comb begin
        int unsigned j;
        sel_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            j = LSB_FIRST ? (WIDTH - 1 - i) : i;
            if (pend[j]) begin
                sel_idx = IDX_W'(j);
            end
        end
        sel_onehot = WIDTH'(1) << sel_idx;
        sel_last   = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);
    end

    always_comb begin
        next_state = state;
        pend_next  = pend;
        zero_next  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_mask != '0) begin
                        pend_next  = in_mask;
                        next_state = EMIT;
                    end else begin
                        zero_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_next = pend & ~sel_onehot;
                    if (sel_last) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            zero_mask <= 1'b0;
        end else begin
            state     <= next_state;
            pend      <= pend_next;
            zero_mask <= zero_next;
        end
    end

    assign in_ready   = (state == IDLE) && !reset;
    assign out_valid  = (state == EMIT);
    assign out_index  = out_valid ? sel_idx : '0;
    assign out_onehot = out_valid ? sel_onehot : '0;
    assign out_last   = out_valid && sel_last;

endmodule
